// File: rtl/timer_cfg_seq_if.sv
// Timer register bus shared between the configuration sequencer and the timer.
interface timer_cfg_seq_if;
  logic       write;
  logic       read;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       sel;

  modport master (output write, output read, output addr, output wdata,
                  output sel, input rdata);
  modport slave  (input write, input read, input addr, input wdata,
                  input sel, output rdata);
endinterface

// File: rtl/timer_cfg_seq.sv
// Timer configuration sequencer: stops the timer, programs timer1/timer2,
// reads both back, retries the whole sequence on a readback mismatch and
// finally writes the run bit (or the stopped value on repeated failure).
module timer_cfg_seq #(
  parameter int         RETRY_MAX   = 2,
  parameter logic [7:0] RUN_DEFAULT = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       cfg_t1,
  input  logic [7:0]       cfg_t2,
  input  logic             cfg_run,
  input  logic             cfg_sel,
  timer_cfg_seq_if.master  bus,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [3:0] {
    S_IDLE, S_STOP_W, S_T1_W, S_T2_W, S_T1_R, S_T2_R, S_RUN_W, S_ABORT_W, S_FIN
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP, PH_STROBE, PH_RECOVER
  } phase_t;

  localparam logic [2:0] RMAX = 3'(RETRY_MAX);

  state_t     state, state_nxt;
  phase_t     phase, phase_nxt;
  logic [2:0] retry_cnt;
  logic       mis;
  logic       sel_q;
  logic       err_q;

  logic [7:0] cap_t1, cap_t2;
  logic       cap_run, cap_sel;

  logic       accept;
  logic       retry_go;
  logic       wr_c, rd_c, busy_c, done_c;
  logic [1:0] addr_c;
  logic [7:0] wdata_c;
  logic       acc_wr;
  logic [1:0] acc_addr;
  logic [7:0] acc_wdata;
  logic [7:0] rd_expect;

  assign accept    = (state == S_IDLE) && start;
  assign rd_expect = (state == S_T1_R) ? cap_t1 : cap_t2;

  // State and access-phase register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      phase <= PH_SETUP;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
    end
  end

  // Next-state sequencing and bus/status outputs
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    retry_go  = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    wr_c      = 1'b0;
    rd_c      = 1'b0;
    addr_c    = 2'b00;
    wdata_c   = 8'h00;
    acc_wr    = 1'b0;
    acc_addr  = 2'b00;
    acc_wdata = 8'h00;

    // Address, data and direction of the access owned by the current state
    case (state)
      S_STOP_W:  begin acc_wr = 1'b1; acc_addr = 2'b00; acc_wdata = RUN_DEFAULT;      end
      S_T1_W:    begin acc_wr = 1'b1; acc_addr = 2'b01; acc_wdata = cap_t1;           end
      S_T2_W:    begin acc_wr = 1'b1; acc_addr = 2'b10; acc_wdata = cap_t2;           end
      S_T1_R:    begin acc_wr = 1'b0; acc_addr = 2'b01;                               end
      S_T2_R:    begin acc_wr = 1'b0; acc_addr = 2'b10;                               end
      S_RUN_W:   begin acc_wr = 1'b1; acc_addr = 2'b00; acc_wdata = {7'b0, cap_run};  end
      S_ABORT_W: begin acc_wr = 1'b1; acc_addr = 2'b00; acc_wdata = RUN_DEFAULT;      end
      default:   begin acc_wr = 1'b0; acc_addr = 2'b00; acc_wdata = 8'h00;            end
    endcase

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_STOP_W;
          phase_nxt = PH_SETUP;
        end
      end
      S_FIN: begin
        done_c    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        busy_c = 1'b1;
        case (phase)
          PH_SETUP: begin
            addr_c    = acc_addr;
            wdata_c   = acc_wdata;
            phase_nxt = PH_STROBE;
          end
          PH_STROBE: begin
            addr_c    = acc_addr;
            wdata_c   = acc_wdata;
            wr_c      = acc_wr;
            rd_c      = !acc_wr;
            phase_nxt = PH_RECOVER;
          end
          default: begin
            // RECOVER: bus idle, decide where the next access goes
            phase_nxt = PH_SETUP;
            case (state)
              S_STOP_W: state_nxt = S_T1_W;
              S_T1_W:   state_nxt = S_T2_W;
              S_T2_W:   state_nxt = S_T1_R;
              S_T1_R, S_T2_R: begin
                if (mis) begin
                  if (retry_cnt < RMAX) begin
                    retry_go  = 1'b1;
                    state_nxt = S_STOP_W;
                  end else begin
                    state_nxt = S_ABORT_W;
                  end
                end else begin
                  state_nxt = (state == S_T1_R) ? S_T2_R : S_RUN_W;
                end
              end
              S_RUN_W:   state_nxt = S_FIN;
              S_ABORT_W: state_nxt = S_FIN;
              default:   state_nxt = S_IDLE;
            endcase
          end
        endcase
      end
    endcase
  end

  // Retry count, readback mismatch flag, clock select and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt <= 3'd0;
      mis       <= 1'b0;
      sel_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        retry_cnt <= 3'd0;
        err_q     <= 1'b0;
      end else if (retry_go) begin
        retry_cnt <= retry_cnt + 3'd1;
      end
      if (rd_c)
        mis <= (bus.rdata != rd_expect);
      if (state == S_STOP_W && phase == PH_RECOVER)
        sel_q <= cap_sel;
      if (state == S_ABORT_W && phase == PH_RECOVER)
        err_q <= 1'b1;
    end
  end

  // Configuration snapshot taken when a request is accepted
  always_ff @(posedge clk) begin
    if (accept) begin
      cap_t1  <= cfg_t1;
      cap_t2  <= cfg_t2;
      cap_run <= cfg_run;
      cap_sel <= cfg_sel;
    end
  end

  assign bus.write = wr_c;
  assign bus.read  = rd_c;
  assign bus.addr  = addr_c;
  assign bus.wdata = wdata_c;
  assign bus.sel   = sel_q;
  assign busy      = busy_c;
  assign done      = done_c;
  assign err       = err_q;

endmodule
